// File: rtl/kugelblitz_rx_frame_gate.sv
// Store-and-forward RX gate: buffers each MAC frame and releases it only
// once it ends cleanly. Bad frames and frames that do not fit are dropped.
module kugelblitz_rx_frame_gate #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int DEPTH           = 64
) (
    input  logic                       kg_clk,
    input  logic                       kg_rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tuser,
    output logic                       s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [31:0]                stat_good_frames,
    output logic [31:0]                stat_bad_frames,
    output logic [31:0]                stat_overflow_frames,
    output logic                       status_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    typedef enum logic {ACCEPT, DROP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
    // Read side sees commits one cycle late, giving the 2-cycle release.
    logic [PW-1:0] vis_q;
    logic [31:0]   good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;
    logic          pulse_q, pulse_d;
    logic          mvalid_q, mvalid_d;
    logic [EW-1:0] mbeat_q;
    logic [EW-1:0] mem [DEPTH];

    logic full, empty, accept, we, load;

    assign s_axis_tready = ~kg_rst;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign full          = (wr_q - rd_q) == FULL_CNT;
    assign empty         = rd_q == vis_q;
    assign load          = ~empty & (~mvalid_q | m_axis_tready);

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        commit_d = commit_q;
        good_d   = good_q;
        bad_d    = bad_q;
        ovf_d    = ovf_q;
        pulse_d  = 1'b0;
        we       = 1'b0;
        rd_d     = load ? rd_q + 1'b1 : rd_q;
        mvalid_d = load ? 1'b1 : (m_axis_tready ? 1'b0 : mvalid_q);
        if (accept) begin
            unique case (state_q)
                ACCEPT: begin
                    if (full) begin
                        if (s_axis_tlast) begin
                            wr_d    = commit_q;
                            ovf_d   = ovf_q + 1'b1;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        we   = 1'b1;
                        wr_d = wr_q + 1'b1;
                        if (s_axis_tlast) begin
                            if (s_axis_tuser) begin
                                wr_d  = commit_q;
                                bad_d = bad_q + 1'b1;
                            end else begin
                                commit_d = wr_q + 1'b1;
                                good_d   = good_q + 1'b1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        wr_d    = commit_q;
                        ovf_d   = ovf_q + 1'b1;
                        pulse_d = 1'b1;
                        state_d = ACCEPT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge kg_clk or posedge kg_rst) begin
        if (kg_rst) begin
            state_q  <= ACCEPT;
            wr_q     <= '0;
            commit_q <= '0;
            vis_q    <= '0;
            rd_q     <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            ovf_q    <= '0;
            pulse_q  <= 1'b0;
            mvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            commit_q <= commit_d;
            vis_q    <= commit_q;
            rd_q     <= rd_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            ovf_q    <= ovf_d;
            pulse_q  <= pulse_d;
            mvalid_q <= mvalid_d;
        end
    end

    always_ff @(posedge kg_clk) begin
        if (we) begin
            mem[wr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
        if (load) begin
            mbeat_q <= mem[rd_q[AW-1:0]];
        end
    end

    assign m_axis_tvalid        = mvalid_q;
    assign m_axis_tdata         = mbeat_q[AXIS_DATA_WIDTH-1:0];
    assign m_axis_tkeep         = mbeat_q[AXIS_DATA_WIDTH +: AXIS_KEEP_WIDTH];
    assign m_axis_tlast         = mbeat_q[EW-1];
    assign stat_good_frames     = good_q;
    assign stat_bad_frames      = bad_q;
    assign stat_overflow_frames = ovf_q;
    assign status_overflow      = pulse_q;

endmodule

// File: tb/tb_kugelblitz_rx_frame_gate.sv
// Scoreboard bench for kugelblitz_rx_frame_gate: directed frames in,
// expected good beats queued, a monitor pops and compares every output beat.
module tb_kugelblitz_rx_frame_gate;

    localparam int DW    = 64;
    localparam int KW    = 8;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          kg_clk = 1'b0;
    logic          kg_rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [31:0]   stat_good_frames;
    logic [31:0]   stat_bad_frames;
    logic [31:0]   stat_overflow_frames;
    logic          status_overflow;

    kugelblitz_rx_frame_gate #(
        .AXIS_DATA_WIDTH(DW),
        .AXIS_KEEP_WIDTH(KW),
        .DEPTH(DEPTH)
    ) dut (
        .kg_clk(kg_clk),
        .kg_rst(kg_rst),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .stat_good_frames(stat_good_frames),
        .stat_bad_frames(stat_bad_frames),
        .stat_overflow_frames(stat_overflow_frames),
        .status_overflow(status_overflow)
    );

    always #5 kg_clk = ~kg_clk;

    beat_t exp_q[$];
    beat_t mon_got;
    beat_t mon_exp;
    int    tests = 0;
    int    fails = 0;
    int    pulses = 0;
    int    outs = 0;
    bit    rand_rdy = 1'b0;
    bit    rdy_fix = 1'b1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a beat is transferred at the next rising edge.
    always @(negedge kg_clk) begin
        if (status_overflow) pulses++;
        if (!kg_rst && m_axis_tvalid && m_axis_tready) begin
            mon_got = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast};
            outs++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: got %0h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    fails++;
                    $display("FAIL beat: got %0h expected %0h", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge kg_clk);
            #1;
            m_axis_tready = rand_rdy ? ($urandom_range(0, 7) != 0) : rdy_fix;
        end
    end

    function automatic beat_t mk(input int base, input int i, input int n,
                                 input bit term);
        beat_t b;
        b.d = {base[31:0], i[31:0]};
        b.l = term && (i == n - 1);
        b.k = b.l ? KW'((1 << ((n % 8) + 1)) - 1) : '1;
        return b;
    endfunction

    task automatic send(input int base, input int n, input bit bad,
                        input bit expect_out, input bit term);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            @(posedge kg_clk);
            #1;
            b = mk(base, i, n, term);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = b.d;
            s_axis_tkeep  = b.k;
            s_axis_tlast  = b.l;
            s_axis_tuser  = bad && b.l;
            if (expect_out) exp_q.push_back(b);
        end
    endtask

    task automatic idle();
        @(posedge kg_clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 3000) begin
            @(posedge kg_clk);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
        end
        repeat (4) @(posedge kg_clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_good", 64'(stat_good_frames), 64'd0);
        check("rst_ovf", 64'(stat_overflow_frames), 64'd0);
        check("rst_pulse", 64'(status_overflow), 64'd0);
        repeat (2) @(negedge kg_clk);
        kg_rst = 1'b0;
        #1;
        check("run_tready", 64'(s_axis_tready), 64'd1);

        // 5-beat good frame with latency check
        send(1, 5, 1'b0, 1'b1, 1'b1);
        idle();
        check("lat_e0", 64'(m_axis_tvalid), 64'd0);
        @(posedge kg_clk);
        #1;
        check("lat_e1", 64'(m_axis_tvalid), 64'd0);
        @(posedge kg_clk);
        #1;
        check("lat_e2", 64'(m_axis_tvalid), 64'd1);
        drain();
        check("good_after_5", 64'(stat_good_frames), 64'd1);

        // bad 3-beat then good 2-beat
        send(2, 3, 1'b1, 1'b0, 1'b1);
        send(3, 2, 1'b0, 1'b1, 1'b1);
        idle();
        drain();
        check("bad_cnt", 64'(stat_bad_frames), 64'd1);
        check("good_after_bad", 64'(stat_good_frames), 64'd2);

        // 40 + 30 beats with output stalled
        rdy_fix = 1'b0;
        repeat (2) @(posedge kg_clk);
        pulses = 0;
        send(4, 40, 1'b0, 1'b1, 1'b1);
        send(5, 30, 1'b0, 1'b0, 1'b1);
        idle();
        repeat (5) @(posedge kg_clk);
        #1;
        check("ovf_pulses", 64'(pulses), 64'd1);
        check("ovf_cnt", 64'(stat_overflow_frames), 64'd1);
        check("stalled_tvalid", 64'(m_axis_tvalid), 64'd1);
        rdy_fix = 1'b1;
        drain();
        check("good_after_40", 64'(stat_good_frames), 64'd3);

        // 65-beat frame never fits
        send(6, 65, 1'b0, 1'b0, 1'b1);
        idle();
        repeat (5) @(posedge kg_clk);
        #1;
        check("ovf_65", 64'(stat_overflow_frames), 64'd2);
        check("ovf_pulses_65", 64'(pulses), 64'd2);
        check("tvalid_65", 64'(m_axis_tvalid), 64'd0);
        send(7, 4, 1'b0, 1'b1, 1'b1);
        idle();
        drain();
        check("good_after_65", 64'(stat_good_frames), 64'd4);

        // 200 back-to-back single-beat frames, random output ready
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) send(1000 + i, 1, 1'b0, 1'b1, 1'b1);
        idle();
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge kg_clk);
        #1;
        check("good_200", 64'(stat_good_frames), 64'd204);
        check("ovf_200", 64'(stat_overflow_frames), 64'd2);
        check("bad_200", 64'(stat_bad_frames), 64'd1);

        // reset with 10 beats of an unfinished frame buffered
        send(8, 10, 1'b0, 1'b0, 1'b0);
        @(posedge kg_clk);
        #2;
        kg_rst = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_tready", 64'(s_axis_tready), 64'd0);
        check("mid_rst_good", 64'(stat_good_frames), 64'd0);
        check("mid_rst_bad", 64'(stat_bad_frames), 64'd0);
        check("mid_rst_ovf", 64'(stat_overflow_frames), 64'd0);
        repeat (2) @(negedge kg_clk);
        kg_rst = 1'b0;
        send(9, 3, 1'b0, 1'b1, 1'b1);
        idle();
        drain();
        check("good_after_rst", 64'(stat_good_frames), 64'd1);
        check("ovf_after_rst", 64'(stat_overflow_frames), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kugelblitz_rx_frame_gate.md
KUGELBLITZ_RX_FRAME_GATE -- requirements
Module: kugelblitz_rx_frame_gate

Interface
REQ-001 The block SHALL have parameter AXIS_DATA_WIDTH, default 512, the stream data width in bits.
REQ-002 The block SHALL have parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8, the tkeep width.
REQ-003 The block SHALL have parameter DEPTH, default 64, the buffer depth in beats; it SHALL be a power of two and at least 4.
REQ-004 The block SHALL have ports kg_clk  in  1  sole clock, rising edge.
REQ-005 The block SHALL have port kg_rst  in  1  reset; one clock, reset asynchronous and active-high.
REQ-006 The block SHALL have ports s_axis_tdata/tkeep/tvalid/tlast/tuser  in  AXIS_DATA_WIDTH/AXIS_KEEP_WIDTH/1/1/1; these carry the MAC receive stream, and tuser=1 on the tlast beat marks a bad frame.
REQ-007 The block SHALL have port s_axis_tready  out  1  input ready.
REQ-008 The block SHALL have ports m_axis_tdata/tkeep/tvalid/tlast  out  AXIS_DATA_WIDTH/AXIS_KEEP_WIDTH/1/1; these carry good frames only toward the offload RX input.
REQ-009 The block SHALL have port m_axis_tready  in  1  output ready.
REQ-010 The block SHALL have ports stat_good_frames, stat_bad_frames, stat_overflow_frames  out  32 each  frame counters.
REQ-011 The block SHALL have port status_overflow  out  1  one-cycle pulse per overflow-dropped frame.

Function
REQ-012 The block SHALL be a store-and-forward buffer; a frame is never emitted on m_axis before its tlast beat is accepted on s_axis.
REQ-013 s_axis_tready SHALL be 1 whenever kg_rst is 0; input is never backpressured, and the block drops frames instead.
REQ-014 The block SHALL keep DEPTH-entry storage plus wr_ptr, commit_ptr and rd_ptr, each log2(DEPTH)+1 bits and wrapping modulo 2*DEPTH.
REQ-015 Full SHALL be defined as (wr_ptr - rd_ptr) == DEPTH; committed-empty SHALL be defined as rd_ptr == commit_ptr.
REQ-016 An accepted beat with the buffer not full and no drop pending SHALL be written at wr_ptr, and wr_ptr SHALL increment.
REQ-017 A tlast beat written with tuser=0 SHALL set commit_ptr to the new wr_ptr and increment stat_good_frames.
REQ-018 A tlast beat with tuser=1 SHALL set wr_ptr back to commit_ptr and increment stat_bad_frames; the frame's beats are discarded.
REQ-019 A beat arriving while the buffer is full SHALL set the drop flag; while the flag is set, beats SHALL be discarded up to and including tlast.
REQ-020 On that tlast, wr_ptr SHALL be set back to commit_ptr, the flag SHALL clear, stat_overflow_frames SHALL increment, and status_overflow SHALL pulse.
REQ-021 Overflow SHALL take precedence over tuser: a bad frame that overflowed SHALL count only as overflow.
REQ-022 A frame longer than DEPTH beats SHALL always be dropped as overflow.
REQ-023 Frame state SHALL be a two-state machine: ACCEPT (writing) and DROP (discarding until tlast); ACCEPT goes to DROP on a full-buffer beat, and DROP goes to ACCEPT after tlast.
REQ-024 The output SHALL be one registered stage fed from storage; m_axis_* SHALL hold stable while tvalid=1 and tready=0.
REQ-025 The first beat of a committed frame SHALL appear with m_axis_tvalid=1 exactly 2 cycles after its tlast input handshake edge, provided the output stage was empty.
REQ-026 The output SHALL sustain one beat per cycle while tready=1 and committed data remains, with no bubbles between frames.
REQ-027 rd_ptr SHALL only advance on beats read out of storage; a wr_ptr rewind SHALL never pass rd_ptr or commit_ptr.
REQ-028 When a commit, a rewind and a read occur in the same cycle, all three SHALL take effect together; space freed by a read SHALL be usable the next cycle.
REQ-029 Counters SHALL wrap from 2^32-1 to 0.
REQ-030 m_axis_tkeep and m_axis_tlast SHALL reproduce the input beat exactly; tuser SHALL not be forwarded.

Reset
REQ-031 Asserting kg_rst SHALL immediately force m_axis_tvalid=0, s_axis_tready=0, status_overflow=0, all pointers to 0, all counters to 0 and the state to ACCEPT.
REQ-032 A frame in flight at reset SHALL be lost entirely; after deassertion, input beats before the next start-of-frame are treated as a new frame.

Verification
REQ-033 Send a 5-beat good frame with tready=1 -> 5 beats out, identical data and tkeep, tvalid 2 cycles after the input tlast, stat_good_frames=1.
REQ-034 Send a 3-beat frame with tuser=1 on tlast, then a 2-beat good frame -> only the 2-beat frame is output; stat_bad_frames=1, stat_good_frames=1.
REQ-035 DEPTH=64 with tready=0, send a 40-beat then a 30-beat frame -> the second frame is dropped, status_overflow pulses once, stat_overflow_frames=1; release tready -> the 40 beats are output intact.
REQ-036 Send a 65-beat frame at DEPTH=64 -> nothing is output, stat_overflow_frames=1, and the next 4-beat good frame passes.
REQ-037 Send back-to-back 1-beat good frames for 200 cycles with random tready -> all frames are output in order, pointers wrap correctly, and stat_good_frames=200.
REQ-038 Assert kg_rst mid-frame with 10 beats buffered -> outputs and counters are 0 at once, and a following good frame passes unaltered.
